// File: rtl/router_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : router_ctrl
//  Purpose  : Packet-sequencing controller for the 1x3 router. Decodes the
//             header address, steers writes into one of three output FIFOs,
//             sequences header/payload/parity loads, stalls the source on a
//             full FIFO and runs a read-timeout watchdog per FIFO.
//  Ports    : clock, reset           - clock (rising edge), async active-high
//             pkt_valid, data_in     - source strobe and byte (addr = [1:0])
//             fifo_full/fifo_empty   - per-FIFO status flags
//             read_enb               - destination read enables
//             parity_done            - parity byte captured by register block
//             low_pkt_valid          - pkt_valid fell during FIFO_FULL_STATE
//             write_enb              - one-hot FIFO write enable
//             soft_reset             - one-cycle watchdog flush per FIFO
//             valid_out              - per-FIFO data-available flag
//             busy                   - source stall
//             detect_add, lfd_state, ld_state, laf_state, full_state,
//             rst_int_reg            - state decodes to the register block
//             fifo_full_sel          - full flag of the selected FIFO
//  Revision : 1.0 - initial release
// ============================================================================
module router_ctrl #(
  parameter int TIMEOUT = 30,  // idle cycles before soft_reset fires
  parameter int CW      = 5    // watchdog counter width, 2**CW > TIMEOUT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic [2:0] write_enb,
  output logic [2:0] soft_reset,
  output logic [2:0] valid_out,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       fifo_full_sel
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  localparam logic [CW-1:0] c_TERM_CNT = CW'(TIMEOUT - 1);

  state_t     state_q;
  logic [1:0] addr_q;
  logic [1:0] hdr_addr;
  logic [1:0] sel;
  logic       hdr_ok;
  logic       abort;
  logic       wr_state;
  logic       unused_data;

  assign hdr_addr    = data_in[1:0];
  assign hdr_ok      = pkt_valid && (hdr_addr != 2'd3);
  assign unused_data = ^data_in[7:2];

  // While decoding, the header on the bus selects the FIFO; afterwards the
  // latched address does.
  assign sel           = (state_q == DECODE_ADDRESS) ? hdr_addr : addr_q;
  assign fifo_full_sel = (sel == 2'd3) ? 1'b0 : fifo_full[sel];
  assign valid_out     = ~fifo_empty;

  // addr_q never holds 3, so this index is always in range.
  assign abort = soft_reset[addr_q] && (state_q != DECODE_ADDRESS);

  // --------------------------------------------------------------------------
  // Sequencing FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
    end else begin
      if ((state_q == DECODE_ADDRESS) && hdr_ok) begin
        addr_q <= hdr_addr;
      end
      if (abort) begin
        // A flush of the FIFO being written kills the packet outright.
        state_q <= DECODE_ADDRESS;
      end else begin
        case (state_q)
          DECODE_ADDRESS: begin
            if (hdr_ok) begin
              state_q <= fifo_empty[hdr_addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
          end
          WAIT_TILL_EMPTY: begin
            if (fifo_empty[addr_q]) begin
              state_q <= LOAD_FIRST_DATA;
            end
          end
          LOAD_FIRST_DATA: state_q <= LOAD_DATA;
          LOAD_DATA: begin
            if (fifo_full_sel) begin
              state_q <= FIFO_FULL_STATE;
            end else if (!pkt_valid) begin
              state_q <= LOAD_PARITY;
            end
          end
          FIFO_FULL_STATE: begin
            if (!fifo_full_sel) begin
              state_q <= LOAD_AFTER_FULL;
            end
          end
          LOAD_AFTER_FULL: begin
            if (parity_done) begin
              state_q <= DECODE_ADDRESS;
            end else if (low_pkt_valid) begin
              state_q <= LOAD_PARITY;
            end else begin
              state_q <= LOAD_DATA;
            end
          end
          LOAD_PARITY: state_q <= CHECK_PARITY_ERROR;
          CHECK_PARITY_ERROR: begin
            state_q <= fifo_full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
          end
          default: state_q <= DECODE_ADDRESS;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Moore decodes
  // --------------------------------------------------------------------------
  assign detect_add  = (state_q == DECODE_ADDRESS);
  assign lfd_state   = (state_q == LOAD_FIRST_DATA);
  assign ld_state    = (state_q == LOAD_DATA);
  assign laf_state   = (state_q == LOAD_AFTER_FULL);
  assign full_state  = (state_q == FIFO_FULL_STATE);
  assign rst_int_reg = (state_q == CHECK_PARITY_ERROR);
  assign busy        = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));

  assign wr_state = (state_q == LOAD_FIRST_DATA) || (state_q == LOAD_DATA) ||
                    (state_q == LOAD_PARITY)     || (state_q == LOAD_AFTER_FULL);

  generate
    for (genvar k = 0; k < 3; k++) begin : g_we
      assign write_enb[k] = (addr_q == 2'(k)) && wr_state;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Read-timeout watchdogs, one per FIFO
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < 3; k++) begin : g_wd
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          sr_q;
      logic          sr_d;
      logic          idle;

      assign idle = valid_out[k] && !read_enb[k];

      // Terminal count restarts the counter instead of wrapping, so a FIFO
      // left unread keeps flushing every TIMEOUT cycles.
      always_comb begin
        cnt_d = '0;
        sr_d  = 1'b0;
        if (idle) begin
          if (cnt_q == c_TERM_CNT) begin
            sr_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
          sr_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          sr_q  <= sr_d;
        end
      end

      assign soft_reset[k] = sr_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_router_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_router_ctrl
//  Purpose  : Directed self-checking bench for router_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_router_ctrl;

  logic       clock;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic       parity_done;
  logic       low_pkt_valid;
  logic [2:0] write_enb;
  logic [2:0] soft_reset;
  logic [2:0] valid_out;
  logic       busy;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       fifo_full_sel;

  int checks_q;
  int errors_q;

  // {detect_add, lfd, ld, laf, full, rst_int_reg, busy}
  localparam logic [6:0] c_S_DA   = 7'b1000000;
  localparam logic [6:0] c_S_LFD  = 7'b0100001;
  localparam logic [6:0] c_S_LD   = 7'b0010000;
  localparam logic [6:0] c_S_LAF  = 7'b0001001;
  localparam logic [6:0] c_S_FULL = 7'b0000101;
  localparam logic [6:0] c_S_CPE  = 7'b0000011;
  localparam logic [6:0] c_S_BUSY = 7'b0000001;  // LOAD_PARITY or WAIT_TILL_EMPTY

  router_ctrl #(.TIMEOUT(30), .CW(5)) dut (
    .clock         (clock),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .read_enb      (read_enb),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .write_enb     (write_enb),
    .soft_reset    (soft_reset),
    .valid_out     (valid_out),
    .busy          (busy),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .fifo_full_sel (fifo_full_sel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_q++;
    if (got !== exp) begin
      errors_q++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] st();
    return {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy};
  endfunction

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    checks_q      = 0;
    errors_q      = 0;
    reset         = 1'b1;
    pkt_valid     = 1'b0;
    data_in       = 8'h00;
    fifo_full     = 3'b000;
    fifo_empty    = 3'b111;
    read_enb      = 3'b000;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;

    // Reset state before any clock edge
    #1;
    check_val("rst_state", st(), c_S_DA);
    check_val("rst_we", write_enb, 3'b000);
    check_val("rst_sr", soft_reset, 3'b000);
    check_val("rst_vo", valid_out, 3'b000);
    tick(); tick();
    reset = 1'b0;
    tick();
    check_val("post_rst_state", st(), c_S_DA);

    // Packet to addr 1, three payload bytes, no stalls
    pkt_valid = 1'b1; data_in = 8'h01;
    #1 check_val("p1_da_busy", busy, 1'b0);
    tick(); check_val("p1_lfd", st(), c_S_LFD); check_val("p1_lfd_we", write_enb, 3'b010);
    data_in = 8'hA0;
    tick(); check_val("p1_ld1", st(), c_S_LD); check_val("p1_ld1_we", write_enb, 3'b010);
    tick(); check_val("p1_ld2", st(), c_S_LD); check_val("p1_ld2_we", write_enb, 3'b010);
    tick(); check_val("p1_ld3", st(), c_S_LD); check_val("p1_ld3_we", write_enb, 3'b010);
    pkt_valid = 1'b0;
    tick(); check_val("p1_lp", st(), c_S_BUSY); check_val("p1_lp_we", write_enb, 3'b010);
    tick(); check_val("p1_cpe", st(), c_S_CPE); check_val("p1_cpe_we", write_enb, 3'b000);
    tick(); check_val("p1_da", st(), c_S_DA); check_val("p1_da_we", write_enb, 3'b000);

    // Header with addr 3 is dropped
    pkt_valid = 1'b1; data_in = 8'h03;
    tick(); check_val("a3_stay1", st(), c_S_DA); check_val("a3_we", write_enb, 3'b000);
    tick(); check_val("a3_stay2", st(), c_S_DA);
    pkt_valid = 1'b0;

    // Packet to addr 0 while FIFO 0 still holds data
    fifo_empty = 3'b110; data_in = 8'h00; pkt_valid = 1'b1;
    #1 check_val("p0_vo", valid_out, 3'b001);
    tick(); check_val("p0_wte1", st(), c_S_BUSY); check_val("p0_wte_we", write_enb, 3'b000);
    tick(); check_val("p0_wte2", st(), c_S_BUSY);
    fifo_empty = 3'b111;
    tick(); check_val("p0_lfd", st(), c_S_LFD); check_val("p0_lfd_we", write_enb, 3'b001);
    pkt_valid = 1'b0;
    tick(); check_val("p0_ld", st(), c_S_LD); check_val("p0_ld_we", write_enb, 3'b001);
    tick(); check_val("p0_lp", st(), c_S_BUSY); check_val("p0_lp_we", write_enb, 3'b001);
    tick(); check_val("p0_cpe", st(), c_S_CPE);
    tick(); check_val("p0_da", st(), c_S_DA);

    // Packet to addr 2 with FIFO-full stalls
    pkt_valid = 1'b1; data_in = 8'h02;
    tick(); check_val("p2_lfd_we", write_enb, 3'b100);
    tick(); check_val("p2_ld", st(), c_S_LD);
    fifo_full = 3'b100;
    #1 check_val("p2_ffsel", fifo_full_sel, 1'b1);
    tick(); check_val("p2_full", st(), c_S_FULL); check_val("p2_full_we", write_enb, 3'b000);
    tick(); check_val("p2_full_hold", st(), c_S_FULL);
    fifo_full = 3'b000; low_pkt_valid = 1'b1;
    tick(); check_val("p2_laf", st(), c_S_LAF); check_val("p2_laf_we", write_enb, 3'b100);
    tick(); check_val("p2_lp", st(), c_S_BUSY); check_val("p2_lp_we", write_enb, 3'b100);
    pkt_valid = 1'b0; low_pkt_valid = 1'b0;
    tick(); check_val("p2_cpe", st(), c_S_CPE);
    fifo_full = 3'b100;
    tick(); check_val("p2_cpe_full", st(), c_S_FULL);
    fifo_full = 3'b000;
    tick(); check_val("p2_laf2", st(), c_S_LAF);
    parity_done = 1'b1;
    tick(); check_val("p2_pdone_da", st(), c_S_DA);
    parity_done = 1'b0;

    // Watchdog: FIFO 1 left unread
    fifo_empty = 3'b101;
    for (int n = 1; n <= 31; n++) begin
      tick();
      check_val($sformatf("wd_n%0d", n), soft_reset, (n == 30) ? 3'b010 : 3'b000);
    end
    fifo_empty = 3'b111;
    tick();

    // Read on the terminal-count edge suppresses the pulse
    fifo_empty = 3'b101;
    for (int n = 1; n <= 29; n++) tick();
    read_enb = 3'b010;
    tick(); check_val("wd_rd_sup", soft_reset, 3'b000);
    read_enb = 3'b000;
    tick(); check_val("wd_rd_after", soft_reset, 3'b000);
    fifo_empty = 3'b111;
    tick();

    // Flush during an addr-1 packet; FIFO 0 flush first has no effect
    pkt_valid = 1'b1; data_in = 8'h01;
    tick(); tick();
    check_val("ab_ld", st(), c_S_LD);
    fifo_empty = 3'b110;
    for (int n = 1; n <= 36; n++) begin
      tick();
      if (n == 5) fifo_empty = 3'b100;
      if (n == 30) begin
        check_val("ab_sr0", soft_reset, 3'b001);
        check_val("ab_ld30", st(), c_S_LD);
      end
      if (n == 31) begin
        check_val("ab_sr0_off", soft_reset, 3'b000);
        check_val("ab_ld31", st(), c_S_LD);
      end
      if (n == 35) begin
        check_val("ab_sr1", soft_reset, 3'b010);
        check_val("ab_ld35", st(), c_S_LD);
        pkt_valid  = 1'b0;
        fifo_empty = 3'b111;
      end
      if (n == 36) begin
        check_val("ab_da", st(), c_S_DA);
        check_val("ab_sr_off", soft_reset, 3'b000);
      end
    end

    // Asynchronous reset in the middle of LOAD_DATA
    pkt_valid = 1'b1; data_in = 8'h02;
    tick(); tick();
    check_val("ar_ld", st(), c_S_LD);
    check_val("ar_ld_we", write_enb, 3'b100);
    reset = 1'b1;
    #1;
    check_val("ar_state", st(), c_S_DA);
    check_val("ar_we", write_enb, 3'b000);
    check_val("ar_sr", soft_reset, 3'b000);
    pkt_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check_val("ar_after", st(), c_S_DA);

    $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
    $finish;
  end

endmodule
`default_nettype wire
